// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-requester banked SRAM arbiter.
package sram_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int NUM_BANK   = 6;
    localparam int BANK_DEPTH = 32768;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 18;
    localparam int LOCAL_W    = $clog2(BANK_DEPTH);
    localparam int BANK_W     = ADDR_W - LOCAL_W;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [BANK_W-1:0] bank;
        logic              err;
    } rsp_pipe_t;

endpackage

// File: rtl/bank_rr_arb.sv
// Per-bank two-way arbiter: grants a lone hit directly, resolves a double hit with a
// 1-bit round-robin pointer that flips only on conflict.
module bank_rr_arb
    import sram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] hit_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic rr_q, rr_d;

    always_comb begin
        rr_d  = rr_q;
        gnt_o = hit_i;
        if (&hit_i) begin
            gnt_o       = '0;
            gnt_o[rr_q] = 1'b1;
            rr_d        = ~rr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/sram_bank_arb.sv
// Crossbar between two requesters and NUM_BANK single-port SRAM banks, with a one-cycle
// read-return pipe that routes bank data back to the issuing requester.
module sram_bank_arb
    import sram_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req_valid_i,
    input  logic [NUM_REQ-1:0]  req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i   [NUM_REQ],
    input  logic [DATA_W-1:0]   req_wdata_i  [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_ready_o,
    output logic [NUM_REQ-1:0]  rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o  [NUM_REQ],
    output logic [NUM_REQ-1:0]  rsp_err_o,
    output logic [NUM_BANK-1:0] bank_cs_o,
    output logic [NUM_BANK-1:0] bank_we_o,
    output logic [LOCAL_W-1:0]  bank_addr_o  [NUM_BANK],
    output logic [DATA_W-1:0]   bank_wdata_o [NUM_BANK],
    input  logic [DATA_W-1:0]   bank_rdata_i [NUM_BANK]
);

    req_t                             req      [NUM_REQ];
    logic [NUM_REQ-1:0]               valid;
    logic [NUM_REQ-1:0]               oor;
    logic [BANK_W-1:0]                bank_idx [NUM_REQ];
    logic [NUM_BANK-1:0][NUM_REQ-1:0] hit;
    logic [NUM_BANK-1:0][NUM_REQ-1:0] gnt;
    rsp_pipe_t                        rsp_d    [NUM_REQ];
    rsp_pipe_t                        rsp_q    [NUM_REQ];

    // Requests are masked during reset so every combinational output reads idle.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req[r].we    = req_we_i[r];
            req[r].addr  = req_addr_i[r];
            req[r].wdata = req_wdata_i[r];
            valid[r]     = req_valid_i[r] & ~rst;
            bank_idx[r]  = req_addr_i[r][ADDR_W-1:LOCAL_W];
            oor[r]       = bank_idx[r] >= BANK_W'(NUM_BANK);
        end
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                hit[b][r] = valid[r] & ~oor[r] & (bank_idx[r] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        bank_rr_arb u_arb (
            .clk   (clk),
            .rst   (rst),
            .hit_i (hit[b]),
            .gnt_o (gnt[b])
        );
    end

    // Out-of-range requests are accepted at once; they never touch a bank.
    always_comb begin
        req_ready_o = valid & oor;
        for (int b = 0; b < NUM_BANK; b++) begin
            req_ready_o = req_ready_o | gnt[b];
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_cs_o[b]    = |gnt[b];
            bank_we_o[b]    = 1'b0;
            bank_addr_o[b]  = '0;
            bank_wdata_o[b] = '0;
            if (bank_cs_o[b]) begin
                bank_we_o[b]    = req[gnt[b][1]].we;
                bank_addr_o[b]  = req[gnt[b][1]].addr[LOCAL_W-1:0];
                bank_wdata_o[b] = req[gnt[b][1]].wdata;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_d[r].valid = req_ready_o[r] & ~req[r].we;
            rsp_d[r].bank  = bank_idx[r];
            rsp_d[r].err   = oor[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= '{default: '0};
        end else begin
            rsp_q <= rsp_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_valid_o[r] = rsp_q[r].valid;
            rsp_err_o[r]   = rsp_q[r].valid & rsp_q[r].err;
            rsp_rdata_o[r] = '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (rsp_q[r].valid && !rsp_q[r].err && rsp_q[r].bank == BANK_W'(b)) begin
                    rsp_rdata_o[r] = bank_rdata_i[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_arb.sv
// Bench for sram_bank_arb: directed vector table, hand-written corner sequences, and a
// randomized run against a flat-address reference model.
module tb_sram_bank_arb;

    localparam int NB    = 6;
    localparam int DEPTH = 32768;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid, req_we, req_ready, rsp_valid, rsp_err;
    logic [17:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [15:0] rsp_rdata [2];
    logic [5:0]  bank_cs, bank_we;
    logic [14:0] bank_addr  [NB];
    logic [15:0] bank_wdata [NB];
    logic [15:0] bank_rdata [NB];

    int n_checks = 0;
    int n_err    = 0;

    sram_bank_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .bank_cs_o    (bank_cs),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_rdata_i (bank_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int b, input int i);
        return 16'(b * 4096 + i * 17 + 3);
    endfunction

    // SRAM macro model: preload, then one synchronous access per selected bank per edge.
    logic [15:0] mem [NB][DEPTH];
    initial begin
        for (int b = 0; b < NB; b++) begin
            bank_rdata[b] = '0;
            for (int i = 0; i < 8; i++) mem[b][256 + i] = pat(b, i);
        end
        mem[0][16] = 16'hA5A5;
        mem[1][16] = 16'h5A5A;
        forever begin
            @(posedge clk);
            for (int b = 0; b < NB; b++) begin
                if (bank_cs[b]) begin
                    if (bank_we[b]) mem[b][bank_addr[b]] = bank_wdata[b];
                    else bank_rdata[b] <= mem[b][bank_addr[b]];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  v, we;
        logic [17:0] a0, a1;
        logic [15:0] d0, d1;
        logic [1:0]  rdy;
        logic [5:0]  cs, bwe;
        logic [1:0]  rspv, err;
        logic [15:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, we, input logic [17:0] a0, a1,
                                input logic [15:0] d0, d1, input logic [1:0] rdy,
                                input logic [5:0] cs, bwe, input logic [1:0] rspv, err,
                                input logic [15:0] rd0, rd1);
        vec_t t;
        t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.cs = cs; t.bwe = bwe; t.rspv = rspv; t.err = err; t.rd0 = rd0; t.rd1 = rd1;
        return t;
    endfunction

    vec_t        tbl [12];
    logic [15:0] ref_mem [int];
    bit          rr_m [NB];
    bit          held [2];
    bit          pend_v [2];
    bit          pend_e [2];
    logic [15:0] pend_d [2];
    int          bk [2];
    bit          oor_m [2];
    bit          g [2];
    logic [5:0]  exp_cs;
    int          g0, g1, win, key;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        for (int r = 0; r < 2; r++) begin
            req_addr[r] = '0;
            req_wdata[r] = '0;
        end

        // Rows: inputs, then ready/cs/we this cycle, then response owed from the previous row.
        tbl[0]  = mk(2'b11, 2'b00, 18'h00010, 18'h08010, 0, 0, 2'b11, 6'b000011, 0,
                     2'b00, 2'b00, 0, 0);
        tbl[1]  = mk(2'b11, 2'b00, 18'h00010, 18'h08010, 0, 0, 2'b11, 6'b000011, 0,
                     2'b11, 2'b00, 16'hA5A5, 16'h5A5A);
        tbl[2]  = mk(2'b11, 2'b11, 18'h10000, 18'h10001, 16'h1111, 16'h2222, 2'b01,
                     6'b000100, 6'b000100, 2'b11, 2'b00, 16'hA5A5, 16'h5A5A);
        tbl[3]  = mk(2'b10, 2'b10, 18'h00000, 18'h10001, 0, 16'h2222, 2'b10,
                     6'b000100, 6'b000100, 2'b00, 2'b00, 0, 0);
        tbl[4]  = mk(2'b11, 2'b00, 18'h10000, 18'h10001, 0, 0, 2'b10, 6'b000100, 0,
                     2'b00, 2'b00, 0, 0);
        tbl[5]  = mk(2'b01, 2'b00, 18'h10000, 18'h00000, 0, 0, 2'b01, 6'b000100, 0,
                     2'b10, 2'b00, 0, 16'h2222);
        tbl[6]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 2'b00, 16'h1111, 0);
        tbl[7]  = mk(2'b11, 2'b10, 18'h30000, 18'h38000, 0, 16'hDEAD, 2'b11, 0, 0,
                     2'b00, 2'b00, 0, 0);
        tbl[8]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 2'b01, 16'h0000, 0);
        tbl[9]  = mk(2'b01, 2'b01, 18'h00020, 0, 16'hBEEF, 0, 2'b01, 6'b000001,
                     6'b000001, 2'b00, 2'b00, 0, 0);
        tbl[10] = mk(2'b01, 2'b00, 18'h00020, 0, 0, 0, 2'b01, 6'b000001, 0,
                     2'b00, 2'b00, 0, 0);
        tbl[11] = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 2'b00, 16'hBEEF, 0);

        #12;
        check("reset_ready", 32'(req_ready), 0);
        check("reset_rsp", {28'd0, rsp_valid, rsp_err}, 0);
        check("reset_bank", {20'd0, bank_cs, bank_we}, 0);
        check("reset_rdata", {rsp_rdata[1], rsp_rdata[0]}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = tbl[i].v;
            req_we = tbl[i].we;
            req_addr[0] = tbl[i].a0;
            req_addr[1] = tbl[i].a1;
            req_wdata[0] = tbl[i].d0;
            req_wdata[1] = tbl[i].d1;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_cs", i), 32'(bank_cs), 32'(tbl[i].cs));
            check($sformatf("vec%0d_we", i), 32'(bank_we), 32'(tbl[i].bwe));
            check($sformatf("vec%0d_rspv", i), 32'(rsp_valid), 32'(tbl[i].rspv));
            if (tbl[i].rspv[0]) begin
                check($sformatf("vec%0d_rdata0", i), 32'(rsp_rdata[0]), 32'(tbl[i].rd0));
                check($sformatf("vec%0d_err0", i), 32'(rsp_err[0]), 32'(tbl[i].err[0]));
            end
            if (tbl[i].rspv[1]) begin
                check($sformatf("vec%0d_rdata1", i), 32'(rsp_rdata[1]), 32'(tbl[i].rd1));
                check($sformatf("vec%0d_err1", i), 32'(rsp_err[1]), 32'(tbl[i].err[1]));
            end
        end

        // Sustained write conflict on bank 3: grants must alternate starting with requester 0.
        g0 = 0;
        g1 = 0;
        req_wdata[0] = 16'h3000;
        req_wdata[1] = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            req_we = 2'b11;
            req_addr[0] = 18'h18000;
            req_addr[1] = 18'h18001;
            #1;
            check($sformatf("conflict%0d_ready", i), 32'(req_ready),
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("conflict%0d_cs", i), 32'(bank_cs), 32'h08);
            g0 += int'(req_ready[0]);
            g1 += int'(req_ready[1]);
            @(posedge clk);
            if (req_ready[0]) req_wdata[0] = req_wdata[0] + 16'd1;
            if (req_ready[1]) req_wdata[1] = req_wdata[1] + 16'd1;
        end
        check("conflict_grants0", 32'(g0), 32'd5);
        check("conflict_grants1", 32'(g1), 32'd5);
        @(negedge clk);
        req_valid = '0;

        // Reset mid-cycle right after a read is granted: its response must never appear.
        @(negedge clk);
        req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0] = 18'h00010;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rspv", 32'(rsp_valid), 0);
        check("midrst_ready", 32'(req_ready), 0);
        check("midrst_bank", {20'd0, bank_cs, bank_we}, 0);
        check("midrst_rdata", {rsp_rdata[1], rsp_rdata[0]}, 0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_rspv", 32'(rsp_valid), 0);

        for (int b = 0; b < NB; b++) begin
            rr_m[b] = 1'b0;
            for (int i = 0; i < 8; i++) ref_mem[b * DEPTH + 256 + i] = pat(b, i);
        end
        for (int r = 0; r < 2; r++) begin
            held[r] = 1'b0;
            pend_v[r] = 1'b0;
            pend_e[r] = 1'b0;
            pend_d[r] = '0;
        end

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!held[r]) begin
                    req_valid[r] = ($urandom % 10) < 7;
                    req_we[r] = 1'($urandom % 2);
                    req_addr[r] = 18'(($urandom % 8) * DEPTH + 256 + ($urandom % 8));
                    req_wdata[r] = 16'($urandom);
                end
            end
            #1;
            for (int r = 0; r < 2; r++) begin
                bk[r] = int'(req_addr[r]) / DEPTH;
                oor_m[r] = bk[r] >= NB;
                g[r] = req_valid[r];
            end
            if (g[0] && g[1] && !oor_m[0] && !oor_m[1] && bk[0] == bk[1]) begin
                win = int'(rr_m[bk[0]]);
                g[1 - win] = 1'b0;
                rr_m[bk[0]] = !rr_m[bk[0]];
            end
            exp_cs = '0;
            for (int r = 0; r < 2; r++) if (g[r] && !oor_m[r]) exp_cs[bk[r]] = 1'b1;

            check("rnd_ready", 32'(req_ready), {30'd0, g[1], g[0]});
            check("rnd_cs", 32'(bank_cs), 32'(exp_cs));
            check("rnd_rspv", 32'(rsp_valid), {30'd0, pend_v[1], pend_v[0]});
            for (int r = 0; r < 2; r++) begin
                if (pend_v[r]) begin
                    check($sformatf("rnd_rdata%0d", r), 32'(rsp_rdata[r]), 32'(pend_d[r]));
                    check($sformatf("rnd_err%0d", r), 32'(rsp_err[r]), 32'(pend_e[r]));
                end
                if (g[r] && !oor_m[r]) begin
                    check($sformatf("rnd_port%0d", r),
                          {bank_we[bk[r]], bank_addr[bk[r]]},
                          {16'd0, req_we[r], 15'(int'(req_addr[r]) % DEPTH)});
                    if (req_we[r]) check($sformatf("rnd_wdata%0d", r),
                                         32'(bank_wdata[bk[r]]), 32'(req_wdata[r]));
                end
            end
            for (int r = 0; r < 2; r++) begin
                key = int'(req_addr[r]);
                pend_v[r] = g[r] && !req_we[r];
                pend_e[r] = oor_m[r];
                pend_d[r] = (oor_m[r] || !ref_mem.exists(key)) ? 16'h0 : ref_mem[key];
                held[r] = req_valid[r] && !g[r];
            end
            for (int r = 0; r < 2; r++) begin
                if (g[r] && req_we[r] && !oor_m[r]) ref_mem[int'(req_addr[r])] = req_wdata[r];
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
